btb_controller: RTL and testbench

//  Direct-mapped Branch Target Buffer for the 5-stage RV32 core.
//  IF presents the fetch word address each cycle. The block returns, combinationally,
//  a hit flag plus the predicted target, so IF can redirect the PC in the same cycle.
//  EX-stage branch resolution writes back taken branches. Direction prediction is

---
 rtl/btb_controller_pkg.sv | 21 ++
 rtl/btb_mem.sv | 56 +++++
 rtl/btb_controller.sv | 72 +++++++
 tb/tb_btb_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/btb_controller_pkg.sv
// Shared types and default sizing for the branch target buffer.
package btb_controller_pkg;

  localparam int unsigned BTB_ADDR_WIDTH = 10;  // fetch word-address width
  localparam int unsigned BTB_IDX_BITS   = 6;   // index bits, depth = 2**BTB_IDX_BITS
  localparam int unsigned XLEN           = 32;

  // Lookup result returned to IF.
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  // Branch resolution from EX.
  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] branch_target;
  } br_cntrl_bus_t;

endpackage

// File: rtl/btb_mem.sv
// BTB storage: valid bit-vector with async clear, tag/target register arrays.
// One asynchronous read port, one synchronous write port.
//   clk, rst     : clock, asynchronous active-low reset (clears valid only)
//   we           : write enable
//   widx/wtag/wtarget : write index and data
//   ridx         : read index
//   rvalid/rtag/rtarget : read data (pre-write contents on same-index collision)
module btb_mem
  import btb_controller_pkg::*;
#(
  parameter int unsigned IDX_BITS = BTB_IDX_BITS,
  parameter int unsigned TAG_W    = BTB_ADDR_WIDTH - BTB_IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_BITS-1:0] widx,
  input  logic [TAG_W-1:0]    wtag,
  input  logic [XLEN-1:0]     wtarget,
  input  logic [IDX_BITS-1:0] ridx,
  output logic                rvalid,
  output logic [TAG_W-1:0]    rtag,
  output logic [XLEN-1:0]     rtarget
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];

  // Valid bits: cleared asynchronously, so a write in a reset cycle is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]    <= wtag;
      target_mem[widx] <= wtarget;
    end
  end

  // Asynchronous read port.
  always_comb begin
    rvalid  = valid[ridx];
    rtag    = tag_mem[ridx];
    rtarget = target_mem[ridx];
  end

endmodule

// File: rtl/btb_controller.sv
// Direct-mapped branch target buffer. IF gets a combinational hit/target for
// the fetch word address; EX writes back taken branches/jumps.
//   clk          : core clock
//   rst          : asynchronous active-low reset
//   read_addr_i  : fetch word address (pc[ADDR_WIDTH+1:2])
//   br_cntrl_i   : EX resolution {taken, pc, branch_target}
//   is_branch_i  : EX slot holds a branch/jump
//   entry_o      : {hit, target} for read_addr_i (target is 0 on miss)
module btb_controller
  import btb_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int unsigned IDX_BITS   = BTB_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  input  br_cntrl_bus_t         br_cntrl_i,
  input  logic                  is_branch_i,
  output btb_entry_t            entry_o
);

  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_BITS;

  logic [IDX_BITS-1:0] ridx;
  logic [TAG_W-1:0]    rtag;
  logic [IDX_BITS-1:0] widx;
  logic [TAG_W-1:0]    wtag;
  logic                we;
  logic                mem_valid;
  logic [TAG_W-1:0]    mem_tag;
  logic [XLEN-1:0]     mem_target;
  logic                unused_pc_bits;

  // Index/tag split of the fetch word address and of the resolved byte PC.
  always_comb begin
    ridx = read_addr_i[IDX_BITS-1:0];
    rtag = read_addr_i[ADDR_WIDTH-1:IDX_BITS];
    widx = br_cntrl_i.pc[IDX_BITS+1:2];
    wtag = br_cntrl_i.pc[ADDR_WIDTH+1:IDX_BITS+2];
    we   = is_branch_i & br_cntrl_i.taken;
  end

  // Byte offset and PC bits above the tag do not take part in the lookup.
  assign unused_pc_bits = ^{br_cntrl_i.pc[XLEN-1:ADDR_WIDTH+2], br_cntrl_i.pc[1:0]};

  btb_mem #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .widx    (widx),
    .wtag    (wtag),
    .wtarget (br_cntrl_i.branch_target),
    .ridx    (ridx),
    .rvalid  (mem_valid),
    .rtag    (mem_tag),
    .rtarget (mem_target)
  );

  // Hit compare; target forced to zero on a miss.
  always_comb begin
    entry_o        = '0;
    entry_o.hit    = mem_valid && (mem_tag == rtag);
    if (entry_o.hit) begin
      entry_o.target = mem_target;
    end
  end

endmodule

// File: tb/tb_btb_controller.sv
// Self-checking bench for btb_controller (ADDR_WIDTH=10, IDX_BITS=6).
module tb_btb_controller;
  import btb_controller_pkg::*;

  logic          clk;
  logic          rst;
  logic [9:0]    read_addr;
  br_cntrl_bus_t br_cntrl;
  logic          is_branch;
  btb_entry_t    entry;

  btb_controller #(
    .ADDR_WIDTH (10),
    .IDX_BITS   (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_addr_i (read_addr),
    .br_cntrl_i  (br_cntrl),
    .is_branch_i (is_branch),
    .entry_o     (entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ra;
    logic        br;
    logic        tk;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        eh;
    logic [31:0] et;
  } vec_t;

  typedef struct {
    int          id;
    logic        eh;
    logic [31:0] et;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [9:0] ra, logic br, logic tk, logic [31:0] pc,
                              logic [31:0] tgt, logic eh, logic [31:0] et);
    vec_t v;
    v.ra = ra; v.br = br; v.tk = tk; v.pc = pc; v.tgt = tgt; v.eh = eh; v.et = et;
    return v;
  endfunction

  // Drive one cycle's inputs and queue the expected lookup result.
  task automatic drive(input int id, input vec_t v);
    exp_t e;
    read_addr              = v.ra;
    is_branch              = v.br;
    br_cntrl.taken         = v.tk;
    br_cntrl.pc            = v.pc;
    br_cntrl.branch_target = v.tgt;
    e.id = id; e.eh = v.eh; e.et = v.et;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the DUT output.
  task automatic sample();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      if (entry.hit !== e.eh || entry.target !== e.et) begin
        n_err++;
        $display("FAIL vec%0d: got hit=%b target=%h, want hit=%b target=%h",
                 e.id, entry.hit, entry.target, e.eh, e.et);
      end
    end
  endtask

  // Apply a vector in the low phase, check before the next rising edge.
  task automatic apply(input int id, input vec_t v);
    @(negedge clk);
    drive(id, v);
    #2;
    sample();
  endtask

  initial begin
    rst                    = 1'b0;
    read_addr              = '0;
    is_branch              = 1'b0;
    br_cntrl               = '0;

    // Reset state visible while rst is low.
    #1;
    drive(1000, mk(10'd16, 0, 0, 0, 0, 0, 0));
    #1 sample();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Every index misses after reset release.
    for (int i = 0; i < 64; i++) apply(2000 + i, mk(10'(i), 0, 0, 0, 0, 0, 0));

    // Main table: write, alias eviction, not-taken/non-branch, read-during-write, extremes.
    vecs.push_back(mk(10'd16,  1, 1, 32'h040, 32'h100, 0, 32'h0));
    vecs.push_back(mk(10'd16,  0, 0, 32'h0,   32'h0,   1, 32'h100));
    vecs.push_back(mk(10'd80,  0, 0, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(10'd80,  1, 1, 32'h140, 32'h200, 0, 32'h0));
    vecs.push_back(mk(10'd80,  0, 0, 32'h0,   32'h0,   1, 32'h200));
    vecs.push_back(mk(10'd16,  0, 0, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(10'd32,  1, 0, 32'h080, 32'h300, 0, 32'h0));
    vecs.push_back(mk(10'd32,  0, 1, 32'h080, 32'h300, 0, 32'h0));
    vecs.push_back(mk(10'd32,  0, 0, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(10'd17,  1, 1, 32'h044, 32'h500, 0, 32'h0));
    vecs.push_back(mk(10'd17,  0, 0, 32'h0,   32'h0,   1, 32'h500));
    vecs.push_back(mk(10'd80,  0, 0, 32'h0,   32'h0,   1, 32'h200));
    vecs.push_back(mk(10'h3FF, 1, 1, 32'hFFC, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(10'h3FF, 0, 0, 32'h0,   32'h0,   1, 32'hDEADBEEF));
    vecs.push_back(mk(10'h03F, 0, 0, 32'h0,   32'h0,   0, 32'h0));
    // Upper PC bits outside the tag are ignored: pc 0xF0000048 maps to word 18.
    vecs.push_back(mk(10'd18,  1, 1, 32'hF0000048, 32'h0000_0003, 0, 32'h0));
    vecs.push_back(mk(10'd18,  0, 0, 32'h0,   32'h0,   1, 32'h0000_0003));
    foreach (vecs[i]) apply(i, vecs[i]);

    // Entries 80, 17, 0x3FF, 18 are populated. Assert reset mid-cycle with a write pending.
    @(negedge clk);
    drive(3000, mk(10'd80, 1, 1, 32'h04C, 32'h600, 1, 32'h200));
    #1 sample();
    rst = 1'b0;
    #1;
    drive(3001, mk(10'd80, 1, 1, 32'h04C, 32'h600, 0, 32'h0));
    #0 sample();
    read_addr = 10'd17;
    drive(3002, mk(10'd17, 1, 1, 32'h04C, 32'h600, 0, 32'h0));
    #1 sample();
    @(posedge clk);   // write to word 19 coincides with reset
    #1;
    drive(3003, mk(10'd19, 1, 1, 32'h04C, 32'h600, 0, 32'h0));
    #1 sample();
    @(negedge clk);
    rst       = 1'b1;
    is_branch = 1'b0;
    br_cntrl  = '0;
    apply(3004, mk(10'd19,  0, 0, 0, 0, 0, 0));
    apply(3005, mk(10'd80,  0, 0, 0, 0, 0, 0));
    apply(3006, mk(10'd17,  0, 0, 0, 0, 0, 0));
    apply(3007, mk(10'h3FF, 0, 0, 0, 0, 0, 0));
    apply(3008, mk(10'd18,  0, 0, 0, 0, 0, 0));
    // Table works again after reset.
    apply(3009, mk(10'd19,  1, 1, 32'h04C, 32'h700, 0, 32'h0));
    apply(3010, mk(10'd19,  0, 0, 0, 0, 1, 32'h700));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
